// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundles the pipeline hazard/stall control signals exchanged between the
//   pipeline datapath and the pipe_ctrl hazard unit.
//   Parameters: REG_SELECT (register-select width), CNT_WIDTH (stall-counter width).
//   master: driven by the datapath. It drives the decode/address/memory status
//           inputs (i_*) and receives the stage controls (o_*).
//   slave : used by pipe_ctrl. It receives i_* and drives o_*.
interface pipe_ctrl_if #(
  parameter int REG_SELECT = 5,
  parameter int CNT_WIDTH  = 16
);
  logic [REG_SELECT-1:0] i_dec_reg_a_select;
  logic [REG_SELECT-1:0] i_dec_reg_b_select;
  logic                  i_dec_uses_a;
  logic                  i_dec_uses_b;
  logic [REG_SELECT-1:0] i_a_reg_c_select;
  logic                  i_a_is_load;
  logic                  i_branch_taken;
  logic                  i_mem_req;
  logic                  i_mem_ready;

  logic                  o_pc_enable;
  logic                  o_d_enable;
  logic                  o_d_flush;
  logic                  o_a_enable;
  logic                  o_a_flush;
  logic                  o_m_enable;
  logic                  o_w_enable;
  logic                  o_mem_valid;
  logic                  o_mem_timeout;
  logic [CNT_WIDTH-1:0]  o_stall_count;
  logic [1:0]            o_state;

  modport master (
    output i_dec_reg_a_select, i_dec_reg_b_select, i_dec_uses_a, i_dec_uses_b,
           i_a_reg_c_select, i_a_is_load, i_branch_taken, i_mem_req, i_mem_ready,
    input  o_pc_enable, o_d_enable, o_d_flush, o_a_enable, o_a_flush,
           o_m_enable, o_w_enable, o_mem_valid, o_mem_timeout, o_stall_count, o_state
  );

  modport slave (
    input  i_dec_reg_a_select, i_dec_reg_b_select, i_dec_uses_a, i_dec_uses_b,
           i_a_reg_c_select, i_a_is_load, i_branch_taken, i_mem_req, i_mem_ready,
    output o_pc_enable, o_d_enable, o_d_flush, o_a_enable, o_a_flush,
           o_m_enable, o_w_enable, o_mem_valid, o_mem_timeout, o_stall_count, o_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Hazard and stall controller for a D/A/M/W pipeline. It resolves memory
//   stalls, taken branches and load-use hazards into per-stage enable/flush
//   controls. It also tracks memory waits with a timeout that latches a
//   terminal FAULT, and counts PC-stall cycles with a saturating counter.
//   Ports:
//     clk - rising-edge clock
//     rst - asynchronous reset, active-low
//     bus - pipe_ctrl_if.slave
//           i_* : decode/address/memory status
//           o_* : stage enables/flushes, memory strobe, timeout flag,
//                 stall count and FSM state (RUN=0, WAIT=1, FAULT=2)
module pipe_ctrl #(
  parameter int REG_SELECT  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [REG_SELECT-1:0] REG_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hazard;
  logic mem_stall;
  logic pc_en, d_en, d_fl, a_en, a_fl, m_en, w_en, mem_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    mem_stall   = 1'b0;
    mem_valid   = 1'b0;
    pc_en       = 1'b0;
    d_en        = 1'b0;
    d_fl        = 1'b0;
    a_en        = 1'b0;
    a_fl        = 1'b0;
    m_en        = 1'b0;
    w_en        = 1'b0;

    // Register 0 is hardwired, so a load targeting it can never feed a hazard.
    lu_hazard = bus.i_a_is_load && (bus.i_a_reg_c_select != REG_ZERO) &&
                ((bus.i_dec_uses_a && (bus.i_dec_reg_a_select == bus.i_a_reg_c_select)) ||
                 (bus.i_dec_uses_b && (bus.i_dec_reg_b_select == bus.i_a_reg_c_select)));

    case (state_q)
      ST_RUN: begin
        mem_valid = bus.i_mem_req;
        mem_stall = bus.i_mem_req && !bus.i_mem_ready;
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        // Ready releases the pipe in the same cycle it arrives, and it beats
        // the timeout when both coincide.
        mem_valid = 1'b1;
        mem_stall = !bus.i_mem_ready;
        if (bus.i_mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d   = ST_FAULT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // A memory stall freezes every stage. Branch and load-use are only acted
    // on once the pipe moves again, so they are simply re-evaluated then.
    if (state_q != ST_FAULT && !mem_stall) begin
      if (bus.i_branch_taken) begin
        pc_en = 1'b1; d_en = 1'b0; d_fl = 1'b1;
        a_en  = 1'b1; a_fl = 1'b1; m_en = 1'b1; w_en = 1'b1;
      end else if (lu_hazard) begin
        pc_en = 1'b0; d_en = 1'b0; d_fl = 1'b0;
        a_en  = 1'b1; a_fl = 1'b1; m_en = 1'b1; w_en = 1'b1;
      end else begin
        pc_en = 1'b1; d_en = 1'b1; d_fl = 1'b0;
        a_en  = 1'b1; a_fl = 1'b0; m_en = 1'b1; w_en = 1'b1;
      end
    end

    if (state_q != ST_FAULT && !pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    // Outputs are combinational, so they must be forced quiet while reset is held.
    if (!rst) begin
      mem_valid = 1'b0;
      pc_en = 1'b0; d_en = 1'b0; d_fl = 1'b0;
      a_en  = 1'b0; a_fl = 1'b0; m_en = 1'b0; w_en = 1'b0;
    end
  end

  assign bus.o_pc_enable   = pc_en;
  assign bus.o_d_enable    = d_en;
  assign bus.o_d_flush     = d_fl;
  assign bus.o_a_enable    = a_en;
  assign bus.o_a_flush     = a_fl;
  assign bus.o_m_enable    = m_en;
  assign bus.o_w_enable    = w_en;
  assign bus.o_mem_valid   = mem_valid;
  assign bus.o_mem_timeout = timeout_q;
  assign bus.o_stall_count = stall_cnt_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl. It runs the directed hazard and
//   memory-wait scenarios, then randomized batches with resets between them.
//   Every cycle is checked against a behavioural model built from the
//   hazard priority rules and a count of consecutive not-ready cycles.
module tb_pipe_ctrl;

  localparam int REG_SELECT  = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic clk;
  logic rst;

  int check_count = 0;
  int fail_count  = 0;

  // Reference model state
  bit m_fault;
  bit m_waiting;
  int m_run_len;
  int m_stall;

  pipe_ctrl_if #(.REG_SELECT(REG_SELECT), .CNT_WIDTH(CNT_WIDTH)) bus ();

  pipe_ctrl #(
    .REG_SELECT (REG_SELECT),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Return the datapath inputs to a quiet state with no hazards.
  task automatic setIdle();
    bus.i_dec_reg_a_select = '0;
    bus.i_dec_reg_b_select = '0;
    bus.i_dec_uses_a       = 1'b0;
    bus.i_dec_uses_b       = 1'b0;
    bus.i_a_reg_c_select   = '0;
    bus.i_a_is_load        = 1'b0;
    bus.i_branch_taken     = 1'b0;
    bus.i_mem_req          = 1'b0;
    bus.i_mem_ready        = 1'b0;
  endtask

  // Assert reset asynchronously between edges and check that the outputs are
  // quiet while it is held. Then release it and clear the model.
  task automatic resetPulse();
    bus.i_mem_req      = 1'b1;
    bus.i_branch_taken = 1'b0;
    rst = 1'b0;
    #2;
    checkOutput("rst_ctrl", {24'd0, bus.o_pc_enable, bus.o_d_enable, bus.o_d_flush, bus.o_a_enable,
                             bus.o_a_flush, bus.o_m_enable, bus.o_w_enable, bus.o_mem_valid}, 32'd0);
    checkOutput("rst_state", 32'(bus.o_state), 32'd0);
    checkOutput("rst_timeout", 32'(bus.o_mem_timeout), 32'd0);
    checkOutput("rst_stall_count", 32'(bus.o_stall_count), 32'd0);
    setIdle();
    m_fault   = 1'b0;
    m_waiting = 1'b0;
    m_run_len = 0;
    m_stall   = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, check all outputs against the model at the
  // falling edge, then advance the model and the DUT by one clock.
  task automatic applyStimulus(input int a_sel, input int b_sel, input bit uses_a, input bit uses_b,
                               input int c_sel, input bit is_load, input bit branch,
                               input bit req, input bit ready);
    bit       ms, lu;
    bit [7:0] exp_ctrl;
    int       exp_state;
    bus.i_dec_reg_a_select = REG_SELECT'(a_sel);
    bus.i_dec_reg_b_select = REG_SELECT'(b_sel);
    bus.i_dec_uses_a       = uses_a;
    bus.i_dec_uses_b       = uses_b;
    bus.i_a_reg_c_select   = REG_SELECT'(c_sel);
    bus.i_a_is_load        = is_load;
    bus.i_branch_taken     = branch;
    bus.i_mem_req          = req;
    bus.i_mem_ready        = ready;

    // Control vector order: pc, d_en, d_flush, a_en, a_flush, m_en, w_en, mem_valid.
    ms = m_waiting ? !ready : (req && !ready);
    lu = is_load && (c_sel != 0) && ((uses_a && a_sel == c_sel) || (uses_b && b_sel == c_sel));
    if (m_fault)       exp_ctrl = 8'b0000000_0;
    else if (ms)       exp_ctrl = {7'b0000000, 1'b1};
    else if (branch)   exp_ctrl = {7'b1011111, m_waiting | req};
    else if (lu)       exp_ctrl = {7'b0001111, m_waiting | req};
    else               exp_ctrl = {7'b1101011, m_waiting | req};
    exp_state = m_fault ? 2 : (m_waiting ? 1 : 0);

    @(negedge clk);
    checkOutput("ctrl", {24'd0, bus.o_pc_enable, bus.o_d_enable, bus.o_d_flush, bus.o_a_enable,
                         bus.o_a_flush, bus.o_m_enable, bus.o_w_enable, bus.o_mem_valid}, {24'd0, exp_ctrl});
    checkOutput("state", 32'(bus.o_state), 32'(exp_state));
    checkOutput("timeout", 32'(bus.o_mem_timeout), 32'(m_fault));
    checkOutput("stall_count", 32'(bus.o_stall_count), 32'(m_stall));

    if (!m_fault) begin
      if (!exp_ctrl[7] && m_stall < CNT_MAX) m_stall++;
      if (m_waiting) begin
        if (ready)                          m_waiting = 1'b0;
        else if (m_run_len == MEM_TIMEOUT)  m_fault   = 1'b1;
        else                                m_run_len++;
      end else if (req && !ready) begin
        m_waiting = 1'b1;
        m_run_len = 1;
      end
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    int ready_pct;
    setIdle();
    rst = 1'b0;
    resetPulse();

    // A load-use hazard on r5 inserts exactly one bubble.
    applyStimulus(1, 5, 0, 1, 5, 1, 0, 0, 0);
    checkOutput("lu_stall_count", 32'(bus.o_stall_count), 32'd1);
    applyStimulus(1, 5, 0, 1, 3, 0, 0, 0, 0);

    // A load to r0 never stalls, even when every select is 0.
    resetPulse();
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 0, 0);
    checkOutput("lu_x0_stall_count", 32'(bus.o_stall_count), 32'd0);

    // A taken branch wins over a simultaneous load-use hazard.
    applyStimulus(5, 5, 1, 1, 5, 1, 1, 0, 0);

    // The memory waits three not-ready cycles, then ready releases the pipe.
    resetPulse();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("wait_stall_count", 32'(bus.o_stall_count), 32'd3);
    checkOutput("wait_state_after", 32'(bus.o_state), 32'd0);

    // Ready never arrives, so the controller faults after four WAIT cycles.
    resetPulse();
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("timeout_state", 32'(bus.o_state), 32'd2);
    checkOutput("timeout_flag", 32'(bus.o_mem_timeout), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetPulse();
    checkOutput("timeout_reset_state", 32'(bus.o_state), 32'd0);

    // Ready arrives on the last allowed WAIT cycle, so no fault is raised.
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("boundary_state", 32'(bus.o_state), 32'd0);
    checkOutput("boundary_timeout", 32'(bus.o_mem_timeout), 32'd0);

    // Randomized batches. Some batches use a low ready rate to provoke timeouts.
    // Each batch starts from an asynchronous reset in an arbitrary state.
    for (int b = 0; b < 20; b++) begin
      ready_pct = (b % 3 == 0) ? 15 : 60;
      for (int c = 0; c < 40; c++) begin
        applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 40,
                      $urandom_range(0, 99) < ready_pct);
      end
      resetPulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
